hc_interval_meter: RTL
======================

# hc_interval_meter

- Measures elapsed cycles between a `start` and a `stop` event by sampling the free-running 32-bit hardware cycle counter value (`hc_in`).
- Sits on the read side of the hardware cycle counter: the counter's output drives `hc_in`, and software/testbench logic consumes the result through a valid/ready output handshake.
- Handles counter wrap-around arithmetically and flags intervals of 2^WIDTH cycles or more.

## Interface
Parameters:
- `WIDTH`, default 32: width of the counter sample and of the elapsed result.

Ports:
- `clk`  in  1: single clock. Same clock as the hardware cycle counter.
- `rst`  in  1: reset; synchronous, active-high.
- `hc_in`  in  WIDTH: current hardware counter value; increments by 1 every cycle.
- `start`  in  1: single-cycle pulse that begins a measurement.
- `stop`  in  1: single-cycle pulse that ends a measurement.
- `abort`  in  1: discards the measurement in progress or the pending result.
- `busy`  out  1: high in RUN and DONE.
- `m_valid`  out  1: result valid.
- `m_ready`  in  1: consumer accepts the result.
- `m_elapsed`  out  WIDTH: `stop` sample minus `start` sample, modulo 2^WIDTH.
- `m_long`  out  1: a full counter wrap occurred during RUN; `m_elapsed` is ambiguous.
- `stat_clear`  in  1: clears the statistics.
- `stat_count`  out  WIDTH: number of accepted results.
- `stat_min`  out  WIDTH: smallest accepted `m_elapsed`.
- `stat_max`  out  WIDTH: largest accepted `m_elapsed`.

## Operation
States: IDLE, RUN, DONE. `rst` forces IDLE from any state, including mid-measurement.

IDLE
- `start`: capture `t0 <= hc_in`, clear the long flag, go to RUN.
- `stop` alone is ignored.
- `start` and `stop` in the same cycle: `start` wins and `stop` is ignored.

RUN
- `stop`: `m_elapsed <= hc_in - t0`, computed as WIDTH-bit unsigned modulo (carry discarded), then go to DONE.
- `start` is ignored; there is no restart.
- If `hc_in == t0` while in RUN (on any cycle after the capture cycle), set the long flag. This is exact because `hc_in` advances by 1 per cycle.
- `abort`: go to IDLE with no result. `abort` has priority over `stop`.

DONE
- `m_valid = 1` and `m_long` = long flag.
- `m_valid && m_ready`: the handshake completes and the state returns to IDLE.
- `abort`: drop the result and go to IDLE.
- `start` and `stop` are ignored, including in the handshake cycle.

Outputs
- `m_elapsed` and `m_long` are held stable while `m_valid` is high.
- Reset values: `busy=0`, `m_valid=0`, `m_elapsed=0`, `m_long=0`, `stat_count=0`, `stat_min` all-ones, `stat_max=0`.

## Timing
- `start` is sampled in cycle N; `t0 = hc_in` at cycle N.
- `stop` is sampled in cycle M; `m_valid` rises at M+1 with `m_elapsed = M-N` (for a counter incrementing by 1 per cycle).
- Minimum interval: `stop` at N+1 gives `m_elapsed=1`.
- The statistics update in the cycle after a handshake completes.
- `stat_clear` takes effect the next cycle. If `stat_clear` coincides with an update, the clear wins.
- `stat_count` saturates at all-ones.

## Configuration
- Macro `HC_STATS_EN`.
  - Defined: on each accepted result, `stat_count` increments and `stat_min`/`stat_max` are updated from `m_elapsed`. Results with `m_long=1` increment the count but do not update min/max.
  - Undefined: the stats ports remain present, are tied to their reset values, and `stat_clear` is ignored.

## Structure
- Shared package `hc_pkg`:
  - `HC_WIDTH = 32`.
  - Enum `hc_meter_state_e {HC_IDLE, HC_RUN, HC_DONE}`.
- Sub-module `hc_stats`: holds count, min and max. Instantiated only under `HC_STATS_EN`.

## Test plan
- Basic measurement:
  - Stimulus: `hc_in` counting from 100; `start` at `hc_in=100`; `stop` at `hc_in=150`; `m_ready=1`.
  - Response: next cycle `m_valid=1`, `m_elapsed=50`, `m_long=0`; then IDLE.
- Wrap-around:
  - Stimulus: `start` at `hc_in=32'hFFFF_FFF0`; `stop` at `hc_in=32'h0000_0010`.
  - Response: `m_elapsed=32`, `m_long=0`.
- Backpressure:
  - Stimulus: `m_ready=0` for 5 cycles after `m_valid`; pulse `start` during DONE; then `m_ready=1`.
  - Response: `m_elapsed` held and `start` ignored; IDLE one cycle after `m_ready`.
- Abort and reset:
  - Stimulus: `abort` in RUN, then `rst` during a second RUN.
  - Response: no `m_valid` in either case; `busy=0`; all outputs at reset values.
- Edge events:
  - Stimulus: `start` and `stop` in the same IDLE cycle, then `stop` one cycle later.
  - Response: `m_elapsed=1`.
- Statistics (`HC_STATS_EN`):
  - Stimulus: intervals 10, 3, 7 accepted, then `stat_clear`.
  - Response: after the intervals, count=3, min=3, max=10; after the clear, count=0, min all-ones, max=0.

Source files
------------

// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared width and state definitions for the cycle-counter interval meter
package hc_pkg;

  localparam int HC_WIDTH = 32;

  typedef enum logic [1:0] {
    HC_IDLE,
    HC_RUN,
    HC_DONE
  } hc_meter_state_e;

endpackage

// File: rtl/hc_stats.sv
// rtl/hc_stats.sv - count/min/max of accepted intervals; instantiated only under HC_STATS_EN
module hc_stats
  import hc_pkg::*;
#(
  parameter int WIDTH = HC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept,
  input  logic [WIDTH-1:0] elapsed,
  input  logic             is_long,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count   <= '0;
      min_val <= '1;
      max_val <= '0;
    end else if (accept) begin
      if (count != '1) begin
        count <= count + 1'b1;
      end
      // An interval that wrapped the counter has no trustworthy length
      if (!is_long) begin
        if (elapsed < min_val) min_val <= elapsed;
        if (elapsed > max_val) max_val <= elapsed;
      end
    end
  end

endmodule

// File: rtl/hc_interval_meter.sv
// rtl/hc_interval_meter.sv - start/stop interval meter on the hardware cycle counter
// Optional statistics block enabled by defining HC_STATS_EN.
module hc_interval_meter
  import hc_pkg::*;
#(
  parameter int WIDTH = HC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] hc_in,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  output logic             busy,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_elapsed,
  output logic             m_long,
  input  logic             stat_clear,
  output logic [WIDTH-1:0] stat_count,
  output logic [WIDTH-1:0] stat_min,
  output logic [WIDTH-1:0] stat_max
);

  hc_meter_state_e state_q, state_d;
  logic [WIDTH-1:0] t0_q;
  logic [WIDTH-1:0] elapsed_q;
  logic             long_q;
  logic             capture;
  logic             finish;
  logic             drop;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) state_q <= HC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    finish  = 1'b0;
    drop    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      HC_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = HC_RUN;
        end
      end
      HC_RUN: begin
        if (abort) begin
          drop    = 1'b1;
          state_d = HC_IDLE;
        end else if (stop) begin
          finish  = 1'b1;
          state_d = HC_DONE;
        end
      end
      HC_DONE: begin
        if (abort) begin
          drop    = 1'b1;
          state_d = HC_IDLE;
        end else if (m_ready) begin
          accept  = 1'b1;
          state_d = HC_IDLE;
        end
      end
      default: state_d = HC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t0_q      <= '0;
      elapsed_q <= '0;
      long_q    <= 1'b0;
    end else begin
      if (capture) begin
        t0_q   <= hc_in;
        long_q <= 1'b0;
      end
      // Counter returning to the start sample means a full wrap has elapsed
      if (state_q == HC_RUN && hc_in == t0_q) begin
        long_q <= 1'b1;
      end
      if (finish) begin
        elapsed_q <= hc_in - t0_q;
      end
      if (drop) begin
        elapsed_q <= '0;
        long_q    <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != HC_IDLE);
  assign m_valid   = (state_q == HC_DONE);
  assign m_elapsed = elapsed_q;
  assign m_long    = long_q && m_valid;

`ifdef HC_STATS_EN
  hc_stats #(
    .WIDTH(WIDTH)
  ) u_stats (
    .clk     (clk),
    .rst     (rst),
    .clear   (stat_clear),
    .accept  (accept),
    .elapsed (elapsed_q),
    .is_long (long_q),
    .count   (stat_count),
    .min_val (stat_min),
    .max_val (stat_max)
  );
`else
  logic unused_stats;
  assign unused_stats = stat_clear ^ accept;
  assign stat_count   = '0;
  assign stat_min     = '1;
  assign stat_max     = '0;
`endif

endmodule
